// File: rtl/hd63701_intc_pkg.sv
// Shared definitions for the HD63701 interrupt capture/arbitration unit:
// FSM state encoding, default vector addresses and the vector helper.
package hd63701_intc_pkg;

   typedef enum logic {
      INTC_ST_IDLE = 1'b0,
      INTC_ST_REQ  = 1'b1
   } intc_st_t;

   // Default vectors, kept equal to the sequencer's own definitions
   localparam logic [7:0] VA_NMI = 8'hFC;
   localparam logic [7:0] VA_IRQ = 8'hF8;

   // Vector address of source i; 8-bit arithmetic wraps modulo 256
   function automatic logic [7:0] vec_of(input logic [7:0] base,
                                         input logic [7:0] step,
                                         input logic [3:0] i);
      return base + step * {4'd0, i};
   endfunction

endpackage

// File: rtl/hd63701_intc_prio.sv
// Combinational priority encoder: the highest set bit wins.
module hd63701_intc_prio #(
   parameter int NSRC = 4
) (
   input  logic [NSRC-1:0] i_req,
   output logic [3:0]      o_idx,
   output logic            o_any
);

   // Scan upward so the last (highest) set bit overwrites the result
   always_comb begin
      o_idx = 4'd0;
      o_any = 1'b0;
      for (int i = 0; i < NSRC; i++) begin
         if (i_req[i]) begin
            o_idx = 4'(i);
            o_any = 1'b1;
         end
      end
   end

endmodule

// File: rtl/hd63701_intc.sv
// Interrupt capture and arbitration for the HD63701 core.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no request outstanding; looking for an eligible source
// REQ   | req=1 to the sequencer, vec/idx frozen until ack or withdrawal
//
// Source NSRC-1 is the NMI: always enabled, not gated by inte, never
// withdrawn once granted.
module hd63701_intc
   import hd63701_intc_pkg::*;
#(
   parameter int              NSRC       = 4,
   parameter logic [NSRC-1:0] LEVEL_MASK = '0,
   parameter logic [7:0]      VBASE      = 8'hF0,
   parameter int              VSTEP      = 4,
   parameter bit              SYNC       = 1'b0
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic [NSRC-1:0] src,
   input  logic [NSRC-1:0] en,
   input  logic            inte,
   input  logic            hold,
   input  logic            ack,
   input  logic            clr_ovf,
   output logic            req,
   output logic [7:0]      vec,
   output logic [3:0]      idx,
   output logic            wake,
   output logic [NSRC-1:0] ovf
);

   localparam logic [NSRC-1:0] LP_NMI_BIT = {1'b1, {(NSRC-1){1'b0}}};
   localparam logic [3:0]      LP_NMI_IDX = 4'(NSRC-1);
   localparam logic [7:0]      LP_STEP    = 8'(VSTEP);

   intc_st_t        r_state;
   intc_st_t        w_state_nxt;

   logic [NSRC-1:0] w_s;
   logic [NSRC-1:0] r_prev;
   logic [NSRC-1:0] r_pend;
   logic [NSRC-1:0] r_ovf;
   logic            r_wake;
   logic [3:0]      r_idx;
   logic [7:0]      r_vec;

   logic [NSRC-1:0] w_edge;
   logic [NSRC-1:0] w_en_eff;
   logic [NSRC-1:0] w_elig;
   logic [NSRC-1:0] w_sel;
   logic [NSRC-1:0] w_clr;
   logic [NSRC-1:0] w_pend_nxt;
   logic [NSRC-1:0] w_ovf_set;
   logic [3:0]      w_win;
   logic            w_any;
   logic            w_cur_elig;
   logic            w_take;
   logic            w_ack;

   // Optional two-flop synchroniser on the raw lines
   generate
      if (SYNC) begin : g_sync
         logic [NSRC-1:0] r_meta;
         logic [NSRC-1:0] r_sync;
         // Two-stage resynchronisation of asynchronous sources
         always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
               r_meta <= '0;
               r_sync <= '0;
            end else begin
               r_meta <= src;
               r_sync <= r_meta;
            end
         end
         assign w_s = r_sync;
      end else begin : g_nosync
         assign w_s = src;
      end
   endgenerate

   // The NMI enable bit is forced on; en[NSRC-1] has no effect
   assign w_en_eff = en | LP_NMI_BIT;
   assign w_edge   = w_s & ~r_prev;
   assign w_elig   = r_pend & (LP_NMI_BIT | (w_en_eff & {NSRC{inte}}));

   hd63701_intc_prio #(
      .NSRC (NSRC)
   ) u_prio (
      .i_req (w_elig),
      .o_idx (w_win),
      .o_any (w_any)
   );

   // One-hot of the granted index, avoids a narrow-vector dynamic index
   always_comb begin
      w_sel = '0;
      for (int i = 0; i < NSRC; i++) begin
         w_sel[i] = (r_idx == 4'(i));
      end
   end

   assign w_cur_elig = |(w_elig & w_sel);
   assign w_take     = (r_state == INTC_ST_IDLE) & w_any & ~hold;
   assign w_ack      = (r_state == INTC_ST_REQ) & ack;

   // Ack only clears edge-mode sources; a new edge in the same cycle wins
   assign w_clr      = w_ack ? (w_sel & ~LEVEL_MASK) : '0;
   assign w_pend_nxt = (LEVEL_MASK & w_s) |
                       (~LEVEL_MASK & (w_edge | (r_pend & ~w_clr)));
   assign w_ovf_set  = w_edge & r_pend & ~w_clr;

   // State register
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state <= INTC_ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic: grant, ack, or withdrawal of a non-NMI request
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         INTC_ST_IDLE: begin
            if (w_take) begin
               w_state_nxt = INTC_ST_REQ;
            end
         end
         INTC_ST_REQ: begin
            if (ack) begin
               w_state_nxt = INTC_ST_IDLE;
            end else if (!w_cur_elig && (r_idx != LP_NMI_IDX)) begin
               w_state_nxt = INTC_ST_IDLE;
            end
         end
         default: w_state_nxt = INTC_ST_IDLE;
      endcase
   end

   // Outputs decoded from the registered state
   always_comb begin
      req = (r_state == INTC_ST_REQ);
   end

   // Edge history, pending, overflow and wake tracking
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_prev <= '0;
         r_pend <= '0;
         r_ovf  <= '0;
         r_wake <= 1'b0;
      end else begin
         r_prev <= w_s;
         r_pend <= w_pend_nxt;
         r_ovf  <= w_ovf_set | (r_ovf & {NSRC{~clr_ovf}});
         r_wake <= |(r_pend & w_en_eff);
      end
   end

   // Grant capture; held frozen for the whole REQ phase
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_idx <= 4'd0;
         r_vec <= 8'h00;
      end else if (w_take) begin
         r_idx <= w_win;
         r_vec <= vec_of(VBASE, LP_STEP, w_win);
      end
   end

   assign vec  = r_vec;
   assign idx  = r_idx;
   assign wake = r_wake;
   assign ovf  = r_ovf;

endmodule

// File: tb/tb_hd63701_intc.sv
// Self-checking bench for hd63701_intc: two instances (all edge, and
// source 1 level-sensitive) driven by the same stimulus and compared each
// cycle with a behavioural model, plus directed scenarios.
module tb_hd63701_intc;

   logic       CLK;
   logic       RST;
   logic [3:0] src;
   logic [3:0] en;
   logic       inte;
   logic       hold;
   logic       ack;
   logic       clr_ovf;

   logic       req_e, req_l;
   logic [7:0] vec_e, vec_l;
   logic [3:0] idx_e, idx_l;
   logic       wake_e, wake_l;
   logic [3:0] ovf_e, ovf_l;

   int n_chk  = 0;
   int n_fail = 0;

   // behavioural model state, one entry per instance
   logic [3:0] m_pend [2];
   logic [3:0] m_prev [2];
   logic [3:0] m_ovf  [2];
   logic       m_wake [2];
   logic       m_busy [2];
   int         m_gidx [2];
   logic [7:0] m_gvec [2];

   hd63701_intc #(.NSRC(4), .LEVEL_MASK(4'b0000)) u_dut_e (
      .CLK(CLK), .RST(RST), .src(src), .en(en), .inte(inte), .hold(hold),
      .ack(ack), .clr_ovf(clr_ovf), .req(req_e), .vec(vec_e), .idx(idx_e),
      .wake(wake_e), .ovf(ovf_e)
   );

   hd63701_intc #(.NSRC(4), .LEVEL_MASK(4'b0010)) u_dut_l (
      .CLK(CLK), .RST(RST), .src(src), .en(en), .inte(inte), .hold(hold),
      .ack(ack), .clr_ovf(clr_ovf), .req(req_l), .vec(vec_l), .idx(idx_l),
      .wake(wake_l), .ovf(ovf_l)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check_val(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int m = 0; m < 2; m++) begin
         m_pend[m] = 4'b0;
         m_prev[m] = 4'b0;
         m_ovf[m]  = 4'b0;
         m_wake[m] = 1'b0;
         m_busy[m] = 1'b0;
         m_gidx[m] = 0;
         m_gvec[m] = 8'h00;
      end
   endtask

   // One clock of the reference behaviour, using the inputs now applied
   task automatic model_step(input int m);
      logic [3:0] lmask;
      logic [3:0] np;
      logic [3:0] no;
      logic       nw;
      bit         elig [4];
      bit         e;
      int         win;
      int         clr;
      lmask = (m == 0) ? 4'b0000 : 4'b0010;
      win = -1;
      clr = -1;
      nw  = 1'b0;
      for (int i = 0; i < 4; i++) begin
         elig[i] = m_pend[m][i] && (i == 3 || (en[i] && inte));
         if (elig[i]) win = i;
         if (m_pend[m][i] && (i == 3 || en[i])) nw = 1'b1;
      end
      if (m_busy[m] && ack && !lmask[m_gidx[m]]) clr = m_gidx[m];
      for (int i = 0; i < 4; i++) begin
         e = src[i] && !m_prev[m][i];
         if (lmask[i]) np[i] = src[i];
         else          np[i] = e || (m_pend[m][i] && clr != i);
         no[i] = (e && m_pend[m][i] && clr != i) || (m_ovf[m][i] && !clr_ovf);
      end
      if (!m_busy[m]) begin
         if (win >= 0 && !hold) begin
            m_busy[m] = 1'b1;
            m_gidx[m] = win;
            m_gvec[m] = 8'((32'hF0 + 4 * win) % 256);
         end
      end else if (ack) begin
         m_busy[m] = 1'b0;
      end else if (m_gidx[m] != 3 && !elig[m_gidx[m]]) begin
         m_busy[m] = 1'b0;
      end
      m_pend[m] = np;
      m_ovf[m]  = no;
      m_wake[m] = nw;
      m_prev[m] = src;
   endtask

   task automatic cmp_all(input string ph);
      check_val($sformatf("%s.e.req", ph),  32'(req_e),  32'(m_busy[0]));
      check_val($sformatf("%s.e.vec", ph),  32'(vec_e),  32'(m_gvec[0]));
      check_val($sformatf("%s.e.idx", ph),  32'(idx_e),  32'(m_gidx[0]));
      check_val($sformatf("%s.e.wake", ph), 32'(wake_e), 32'(m_wake[0]));
      check_val($sformatf("%s.e.ovf", ph),  32'(ovf_e),  32'(m_ovf[0]));
      check_val($sformatf("%s.l.req", ph),  32'(req_l),  32'(m_busy[1]));
      check_val($sformatf("%s.l.vec", ph),  32'(vec_l),  32'(m_gvec[1]));
      check_val($sformatf("%s.l.idx", ph),  32'(idx_l),  32'(m_gidx[1]));
      check_val($sformatf("%s.l.wake", ph), 32'(wake_l), 32'(m_wake[1]));
      check_val($sformatf("%s.l.ovf", ph),  32'(ovf_l),  32'(m_ovf[1]));
   endtask

   task automatic tick(input string ph);
      model_step(0);
      model_step(1);
      @(posedge CLK);
      #1;
      cmp_all(ph);
   endtask

   initial begin
      RST = 1'b1; src = 4'b0; en = 4'b0; inte = 1'b0; hold = 1'b0;
      ack = 1'b0; clr_ovf = 1'b0;
      model_reset();
      repeat (2) @(posedge CLK);
      #1;
      check_val("rst.req",  32'(req_e),  32'h0);
      check_val("rst.vec",  32'(vec_e),  32'h00);
      check_val("rst.idx",  32'(idx_e),  32'h0);
      check_val("rst.wake", 32'(wake_e), 32'h0);
      check_val("rst.ovf",  32'(ovf_e),  32'h0);
      @(negedge CLK);
      RST = 1'b0;
      repeat (3) tick("idle");

      // NMI with inte=0: pend after edge k, req after k+1
      src = 4'b1000;
      tick("nmi");
      check_val("nmi.req_k", 32'(req_e), 32'h0);
      src = 4'b0000;
      tick("nmi");
      check_val("nmi.req_k1", 32'(req_e), 32'h1);
      check_val("nmi.vec", 32'(vec_e), 32'hFC);
      check_val("nmi.idx", 32'(idx_e), 32'h3);
      ack = 1'b1;
      tick("nmi");
      check_val("nmi.req_ack", 32'(req_e), 32'h0);
      ack = 1'b0;
      tick("nmi");
      check_val("nmi.pend_clr", 32'(wake_e), 32'h0);

      // two simultaneous sources, higher index first
      inte = 1'b1; en = 4'hF;
      src = 4'b0110;
      tick("pri");
      src = 4'b0000;
      tick("pri");
      check_val("pri.vec1", 32'(vec_e), 32'hF8);
      ack = 1'b1;
      tick("pri");
      check_val("pri.gap", 32'(req_e), 32'h0);
      ack = 1'b0;
      tick("pri");
      check_val("pri.req2", 32'(req_e), 32'h1);
      check_val("pri.vec2", 32'(vec_e), 32'hF4);
      ack = 1'b1;
      tick("pri");
      ack = 1'b0;
      tick("pri");

      // grant frozen while a higher source arrives
      src = 4'b0001;
      tick("frz");
      src = 4'b0000;
      tick("frz");
      check_val("frz.vec0", 32'(vec_e), 32'hF0);
      src = 4'b1000;
      tick("frz");
      check_val("frz.hold_vec", 32'(vec_e), 32'hF0);
      src = 4'b0000;
      tick("frz");
      check_val("frz.hold_req", 32'(req_e), 32'h1);
      ack = 1'b1;
      tick("frz");
      ack = 1'b0;
      tick("frz");
      check_val("frz.next_vec", 32'(vec_e), 32'hFC);
      ack = 1'b1;
      tick("frz");
      ack = 1'b0;
      tick("frz");

      // overflow and set-wins-over-ack
      src = 4'b0100;
      tick("ovf");
      src = 4'b0000;
      tick("ovf");
      src = 4'b0100;
      tick("ovf");
      check_val("ovf.set", 32'(ovf_e), 32'h4);
      src = 4'b0000;
      tick("ovf");
      src = 4'b0100; ack = 1'b1;
      tick("ovf");
      src = 4'b0000; ack = 1'b0;
      tick("ovf");
      check_val("ovf.pend_kept", 32'(req_e), 32'h1);
      check_val("ovf.vec", 32'(vec_e), 32'hF8);
      clr_ovf = 1'b1;
      tick("ovf");
      clr_ovf = 1'b0;
      check_val("ovf.clr", 32'(ovf_e), 32'h0);
      ack = 1'b1;
      tick("ovf");
      ack = 1'b0;
      tick("ovf");

      // level source 1 on the second instance
      src = 4'b0010;
      tick("lvl");
      tick("lvl");
      check_val("lvl.req", 32'(req_l), 32'h1);
      check_val("lvl.vec", 32'(vec_l), 32'hF4);
      ack = 1'b1;
      tick("lvl");
      ack = 1'b0;
      tick("lvl");
      check_val("lvl.ack_noclr", 32'(req_l), 32'h1);
      src = 4'b0000;
      tick("lvl");
      tick("lvl");
      check_val("lvl.withdraw", 32'(req_l), 32'h0);
      repeat (2) tick("lvl");

      // hold shadow, then reset in the middle of REQ
      hold = 1'b1;
      src = 4'b0100;
      tick("hold");
      src = 4'b0000;
      tick("hold");
      tick("hold");
      check_val("hold.noreq", 32'(req_e), 32'h0);
      check_val("hold.wake", 32'(wake_e), 32'h1);
      hold = 1'b0;
      tick("hold");
      check_val("hold.release", 32'(req_e), 32'h1);
      #3;
      RST = 1'b1;
      #1;
      check_val("arst.req", 32'(req_e), 32'h0);
      check_val("arst.vec", 32'(vec_e), 32'h00);
      check_val("arst.req_l", 32'(req_l), 32'h0);
      model_reset();
      @(negedge CLK);
      RST = 1'b0;
      tick("post_rst");

      // randomized phase
      for (int c = 0; c < 800; c++) begin
         src     = src ^ (4'($urandom) & 4'($urandom));
         ack     = ($urandom_range(0, 2) == 0);
         hold    = ($urandom_range(0, 9) == 0);
         clr_ovf = ($urandom_range(0, 19) == 0);
         if ($urandom_range(0, 15) == 0) en = 4'($urandom);
         if ($urandom_range(0, 7) == 0)  inte = ~inte;
         tick("rnd");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
